// File: rtl/msg_tx_sched_pkg.sv
// Shared state encodings and default widths for the message transmit scheduler.
package msg_tx_sched_pkg;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_LEN_W  = 6;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_SEND  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

endpackage

// File: rtl/msg_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer, with wrap.
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int PTR_W = 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             any_o
);

    int k;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        k     = 0;
        for (int i = 0; i < NREQ; i++) begin
            k = (int'(ptr_i) + i) % NREQ;
            if (!any_o && req_i[k]) begin
                any_o    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = PTR_W'(k);
            end
        end
    end

endmodule

// File: rtl/msg_tx_sched.sv
// Shares one character ROM and one serial transmitter between NREQ requesters,
// walking the ROM from a latched base address and pacing characters by busy and gap.
module msg_tx_sched
    import msg_tx_sched_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int LEN_W    = DEF_LEN_W,
    parameter int ROM_LAT  = 1,
    parameter int CHAR_GAP = 78105
) (
    input  logic                     sysclk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*ADDR_W-1:0]   req_base,
    input  logic [NREQ*LEN_W-1:0]    req_len,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [7:0]               rom_data,
    output logic [7:0]               tx_data,
    output logic                     tx_start,
    input  logic                     tx_busy,
    output logic                     busy
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int GAP_W = $clog2(CHAR_GAP);
    localparam int LAT_W = $clog2(ROM_LAT + 1);

    logic [2:0]        state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [PTR_W-1:0]  gidx_q, gidx_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        txd_q, txd_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              first_q, first_d;

    logic [NREQ-1:0]   arb_gnt;
    logic [PTR_W-1:0]  arb_idx;
    logic              arb_any;
    int                sel;

    rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        base_d  = base_q;
        len_d   = len_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        txd_d   = txd_q;
        lat_d   = lat_q;
        first_d = first_q;
        gap_d   = (gap_q != '0) ? gap_q - GAP_W'(1) : '0;
        sel     = int'(arb_idx);
        case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    gnt_d   = arb_gnt;
                    gidx_d  = arb_idx;
                    base_d  = req_base[sel*ADDR_W +: ADDR_W];
                    len_d   = req_len[sel*LEN_W +: LEN_W];
                    idx_d   = '0;
                    addr_d  = req_base[sel*ADDR_W +: ADDR_W];
                    lat_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // Empty messages finish straight from here with no character issued.
                if (len_q == '0) begin
                    gnt_d   = '0;
                    done_d  = gnt_q;
                    state_d = S_FIN;
                end else if (lat_q == LAT_W'(ROM_LAT)) begin
                    txd_d   = rom_data;
                    state_d = S_SEND;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            S_SEND: begin
                gap_d   = GAP_W'(CHAR_GAP - 1);
                idx_d   = idx_q + LEN_W'(1);
                first_d = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // The transmitter may not have raised busy yet in the first cycle.
                first_d = 1'b0;
                if (!first_q && !tx_busy && gap_q == '0) begin
                    if (idx_q == len_q) begin
                        gnt_d   = '0;
                        done_d  = gnt_q;
                        state_d = S_FIN;
                    end else begin
                        addr_d  = base_q + ADDR_W'(idx_q);
                        lat_d   = '0;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FIN: begin
                ptr_d   = (int'(gidx_q) == NREQ - 1) ? '0 : gidx_q + PTR_W'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            base_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            txd_q   <= '0;
            gap_q   <= '0;
            lat_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            base_q  <= base_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            txd_q   <= txd_d;
            gap_q   <= gap_d;
            lat_q   <= lat_d;
            first_q <= first_d;
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign rom_addr = addr_q;
    assign tx_data  = txd_q;
    assign tx_start = (state_q == S_SEND);
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_msg_tx_sched.sv
// Randomized scenario bench for msg_tx_sched with a message-level reference model.
module tb_msg_tx_sched;

    localparam int NREQ = 2, AW = 6, LW = 6, GAP = 4;

    logic            sysclk = 1'b0;
    logic            reset  = 1'b1;
    logic [NREQ-1:0] req    = '0;
    logic [NREQ*AW-1:0] req_base = '0;
    logic [NREQ*LW-1:0] req_len  = '0;
    logic [NREQ-1:0] gnt, done;
    logic [AW-1:0]   rom_addr;
    logic [7:0]      rom_data = 8'h00;
    logic [7:0]      tx_data;
    logic            tx_start, tx_busy, busy;
    logic            hold_busy = 1'b0;
    int              bcnt = 0;
    int              cyc  = 0;

    int n_cmp = 0, n_bad = 0;

    logic [7:0]      txd_q[$];
    int              txc_q[$];
    logic [AW-1:0]   txa_q[$];
    logic [NREQ-1:0] txg_q[$];
    logic [NREQ-1:0] dn_q[$];
    int              overlap = 0;
    int              gcyc[NREQ];

    msg_tx_sched #(.NREQ(NREQ), .ADDR_W(AW), .LEN_W(LW), .ROM_LAT(1), .CHAR_GAP(GAP)) dut (
        .sysclk(sysclk), .reset(reset), .req(req), .req_base(req_base), .req_len(req_len),
        .gnt(gnt), .done(done), .rom_addr(rom_addr), .rom_data(rom_data),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .busy(busy)
    );

    always #5 sysclk = ~sysclk;

    // ROM with one cycle of latency; transmitter busy for 3 cycles after each start.
    always @(posedge sysclk) begin
        cyc      <= cyc + 1;
        rom_data <= 8'h40 + {2'b00, rom_addr};
        if (tx_start) bcnt <= 3;
        else if (bcnt > 0) bcnt <= bcnt - 1;
    end
    assign tx_busy = (bcnt != 0) || hold_busy;

    always @(negedge sysclk) begin
        if (tx_start) begin
            txd_q.push_back(tx_data);
            txc_q.push_back(cyc);
            txa_q.push_back(rom_addr);
            txg_q.push_back(gnt);
        end
        if (done != '0) dn_q.push_back(done);
        if ((gnt & (gnt - 1'b1)) != '0) overlap++;
        for (int i = 0; i < NREQ; i++) if (gnt[i]) gcyc[i]++;
    end

    function automatic logic [7:0] exp_char(input int b, input int k);
        return 8'(64 + ((b + k) % 64));
    endfunction

    task automatic start_req(input int r, input int b, input int l);
        req_base[r*AW +: AW] = AW'(b);
        req_len[r*LW +: LW]  = LW'(l);
        req[r] = 1'b1;
    endtask

    // Raise one request in an IDLE cycle; returns req-rise cycle and whether done arrived.
    task automatic run_msg(input int r, input int b, input int l, input bit drop_late,
                           output int t0, output bit ok);
        int n0, ntx;
        n0  = dn_q.size();
        ntx = txd_q.size();
        @(negedge sysclk);
        t0 = cyc;
        start_req(r, b, l);
        for (int i = 0; i < 20 && !gnt[r]; i++) @(negedge sysclk);
        if (drop_late)
            for (int i = 0; i < 100 && txd_q.size() == ntx; i++) @(negedge sysclk);
        req[r]   = 1'b0;
        req_base = ($urandom() << 16) ^ $urandom();
        req_len  = ($urandom() << 16) ^ $urandom();
        for (int i = 0; i < 2000 && dn_q.size() == n0; i++) @(negedge sysclk);
        ok = (dn_q.size() > n0);
    endtask

    task automatic check_msg(input string nm, input int r, input int b, input int l,
                             input int ntx, input bit ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL %s done_timeout got=0 want=1", nm); end
        n_cmp++;
        if (dn_q[$] !== NREQ'(1 << r)) begin
            n_bad++; $display("FAIL %s done got=%b want=%b", nm, dn_q[$], NREQ'(1 << r));
        end
        n_cmp++;
        if (txd_q.size() - ntx != l) begin
            n_bad++; $display("FAIL %s tx_count got=%0d want=%0d", nm, txd_q.size() - ntx, l);
        end
        for (int k = 0; k < l && ntx + k < txd_q.size(); k++) begin
            n_cmp++;
            if (txd_q[ntx+k] !== exp_char(b, k) || txa_q[ntx+k] !== AW'((b + k) % 64)
                || txg_q[ntx+k] !== NREQ'(1 << r)) begin
                n_bad++;
                $display("FAIL %s char%0d data/addr/gnt got=%h/%0d/%b want=%h/%0d/%b", nm, k,
                         txd_q[ntx+k], txa_q[ntx+k], txg_q[ntx+k], exp_char(b, k), (b + k) % 64,
                         NREQ'(1 << r));
            end
            if (k > 0) begin
                n_cmp++;
                if (txc_q[ntx+k] - txc_q[ntx+k-1] < GAP) begin
                    n_bad++;
                    $display("FAIL %s spacing%0d got=%0d want>=%0d", nm, k,
                             txc_q[ntx+k] - txc_q[ntx+k-1], GAP);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge sysclk);
        n_cmp++;
        if ({gnt, done, rom_addr, tx_data, tx_start, busy} !== '0) begin
            n_bad++;
            $display("FAIL reset gnt/done/addr/txd/start/busy got=%b/%b/%0d/%h/%b/%b want=all0",
                     gnt, done, rom_addr, tx_data, tx_start, busy);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        int t0, ntx; bit ok;
        ntx = txd_q.size();
        run_msg(0, 5, 3, 1'b0, t0, ok);
        check_msg("single", 0, 5, 3, ntx, ok);
        n_cmp++;
        if (txc_q[ntx] !== t0 + 3) begin
            n_bad++; $display("FAIL single first_tx_cycle got=%0d want=%0d", txc_q[ntx], t0 + 3);
        end
        @(negedge sysclk);
        n_cmp++;
        if (busy !== 1'b0 || gnt !== '0) begin
            n_bad++; $display("FAIL single idle_after busy/gnt got=%b/%b want=0/00", busy, gnt);
        end
    endtask

    task automatic test_zero_len();
        int t0, ntx, g1; bit ok;
        ntx = txd_q.size();
        g1  = gcyc[1];
        run_msg(1, $urandom_range(0, 63), 0, 1'b0, t0, ok);
        check_msg("zero_len", 1, 0, 0, ntx, ok);
        n_cmp++;
        if (gcyc[1] - g1 != 1) begin
            n_bad++; $display("FAIL zero_len gnt_cycles got=%0d want=1", gcyc[1] - g1);
        end
    endtask

    task automatic test_wrap();
        int t0, ntx; bit ok;
        ntx = txd_q.size();
        run_msg(0, 62, 4, 1'b0, t0, ok);
        check_msg("wrap", 0, 62, 4, ntx, ok);
    endtask

    task automatic test_random();
        int t0, ntx, r, b, l; bit ok;
        for (int n = 0; n < 8; n++) begin
            r = $urandom_range(0, NREQ - 1);
            b = $urandom_range(0, 63);
            l = $urandom_range(1, 6);
            ntx = txd_q.size();
            run_msg(r, b, l, n[0], t0, ok);
            check_msg($sformatf("rand%0d", n), r, b, l, ntx, ok);
        end
    endtask

    task automatic test_contention();
        int ntx, n0, ptr, who, ov0;
        int base[NREQ];
        reset = 1'b1;
        @(negedge sysclk);
        ntx = txd_q.size();
        n0  = dn_q.size();
        ov0 = overlap;
        for (int i = 0; i < NREQ; i++) begin
            base[i] = $urandom_range(0, 63);
            start_req(i, base[i], 2);
        end
        @(negedge sysclk);
        reset = 1'b0;
        for (int i = 0; i < 400 && dn_q.size() < n0 + 3; i++) @(negedge sysclk);
        req = '0;
        n_cmp++;
        if (dn_q.size() < n0 + 3) begin
            n_bad++; $display("FAIL contention done_count got=%0d want=3", dn_q.size() - n0);
        end
        // Both always pending, so the turn order simply rotates from requester 0.
        ptr = 0;
        for (int m = 0; m < 3 && n0 + m < dn_q.size(); m++) begin
            who = ptr;
            ptr = (ptr + 1) % NREQ;
            n_cmp++;
            if (dn_q[n0+m] !== NREQ'(1 << who)) begin
                n_bad++; $display("FAIL contention order%0d got=%b want=%b", m, dn_q[n0+m], NREQ'(1 << who));
            end
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (txd_q[ntx+2*m+k] !== exp_char(base[who], k)) begin
                    n_bad++;
                    $display("FAIL contention msg%0d char%0d got=%h want=%h", m, k,
                             txd_q[ntx+2*m+k], exp_char(base[who], k));
                end
            end
        end
        n_cmp++;
        if (overlap != ov0) begin
            n_bad++; $display("FAIL contention gnt_overlap got=%0d want=0", overlap - ov0);
        end
        for (int i = 0; i < 20 && busy; i++) @(negedge sysclk);
    endtask

    task automatic test_reset_mid();
        int n0, ntx, t0; bit ok;
        n0  = dn_q.size();
        ntx = txd_q.size();
        @(negedge sysclk);
        start_req(0, 20, 5);
        for (int i = 0; i < 100 && txd_q.size() < ntx + 2; i++) @(negedge sysclk);
        @(negedge sysclk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (tx_start !== 1'b0 || gnt !== '0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid start/gnt/busy got=%b/%b/%b want=0/00/0", tx_start, gnt, busy);
        end
        req = '0;
        repeat (3) @(negedge sysclk);
        reset = 1'b0;
        repeat (3) @(negedge sysclk);
        n_cmp++;
        if (dn_q.size() != n0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid no_done dones/busy got=%0d/%b want=0/0", dn_q.size() - n0, busy);
        end
        ntx = txd_q.size();
        run_msg(1, 33, 2, 1'b0, t0, ok);
        check_msg("after_reset", 1, 33, 2, ntx, ok);
        n_cmp++;
        if (txc_q[ntx] !== t0 + 3) begin
            n_bad++; $display("FAIL after_reset first_tx_cycle got=%0d want=%0d", txc_q[ntx], t0 + 3);
        end
    endtask

    task automatic test_pacing();
        int ntx, n0, rel;
        ntx = txd_q.size();
        n0  = dn_q.size();
        @(negedge sysclk);
        start_req(0, 9, 2);
        for (int i = 0; i < 100 && txd_q.size() == ntx; i++) @(negedge sysclk);
        req[0] = 1'b0;
        hold_busy = 1'b1;
        repeat (20) @(negedge sysclk);
        n_cmp++;
        if (txd_q.size() != ntx + 1) begin
            n_bad++; $display("FAIL pacing tx_during_busy got=%0d want=1", txd_q.size() - ntx);
        end
        hold_busy = 1'b0;
        rel = cyc;
        for (int i = 0; i < 100 && dn_q.size() == n0; i++) @(negedge sysclk);
        check_msg("pacing", 0, 9, 2, ntx, dn_q.size() > n0);
        n_cmp++;
        if (txd_q.size() < ntx + 2 || txc_q[ntx+1] <= rel) begin
            n_bad++;
            $display("FAIL pacing second_tx_cycle got=%0d want>%0d",
                     (txd_q.size() > ntx + 1) ? txc_q[ntx+1] : -1, rel);
        end
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) gcyc[i] = 0;
        test_reset();
        test_single();
        test_zero_len();
        test_wrap();
        test_random();
        test_contention();
        test_reset_mid();
        test_pacing();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time_limit got=expired want=finished");
        $fatal(1, "watchdog");
    end

endmodule
